mdu_ctrl: RTL

Multi-cycle multiply/divide controller for the five-stage pipeline. It owns the HI/LO registers and sequences MULT/DIV operations issued from the E stage through a fixed-latency busy window. It serves MFHI/MFLO reads back into the E-stage datapath. It raises a stall request to the hazard/conflict unit so that no MDU-dependent instruction leaves D while a result is pending.

---
 rtl/mdu_defs_pkg.sv | 40 ++++
 rtl/mdu_arith.sv | 49 ++++
 rtl/mdu_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mdu_defs_pkg.sv
// Shared MDU definitions: op codes, FSM encodings, default latencies, op-class helpers.
// MDU_MADD_EN adds the accumulate ops (9-12) to the multiply class.
package mdu_defs_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_t;

   function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      return op inside {OP_MULT, OP_MULTU};
`endif
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: full 64-bit {hi,lo} result for the issued op.
// Divide-by-zero and non-arith ops return the incoming {hi,lo}; MDU_MADD_EN adds accumulate ops.
module mdu_arith
   import mdu_defs_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] res
);

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, q_u, r_u;
   logic        b_zero;

   // Low 64 bits of the sign-extended product equal the signed 64-bit product.
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as q=0x80000000, r=0.
   assign a_mag  = a[31] ? -a : a;
   assign b_mag  = b[31] ? -b : b;
   assign b_zero = (b == 32'd0);
   assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
   assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
   assign q_u    = b_zero ? 32'd0 : a / b;
   assign r_u    = b_zero ? 32'd0 : a % b;

   always_comb begin
      res = {hi, lo};
      case (op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   if (!b_zero) res = {(a[31] ? -r_mag : r_mag),
                                       ((a[31] ^ b[31]) ? -q_mag : q_mag)};
         OP_DIVU:  if (!b_zero) res = {r_u, q_u};
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi, lo} + prod_s;
         OP_MADDU: res = {hi, lo} + prod_u;
         OP_MSUB:  res = {hi, lo} - prod_s;
         OP_MSUBU: res = {hi, lo} - prod_u;
`endif
         default:  res = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: owns HI/LO, runs a fixed busy window per mult/div, serves MF* reads.
// Result is computed at issue and held in pending regs until the window closes. Option: MDU_MADD_EN.
module mdu_ctrl
   import mdu_defs_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdu_valid_E,
   input  logic [3:0]  mdu_op_E,
   input  logic [31:0] src_a_E,
   input  logic [31:0] src_b_E,
   input  logic        mdu_use_D,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_rd_E
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   mdu_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [63:0]   arith_res;
   logic          op_mul, op_div;

   assign op_mul = is_mul_op(mdu_op_E);
   assign op_div = is_div_op(mdu_op_E);

   mdu_arith u_arith (
      .op  (mdu_op_E),
      .a   (src_a_E),
      .b   (src_b_E),
      .hi  (hi_q),
      .lo  (lo_q),
      .res (arith_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (mdu_valid_E) begin
               if (op_mul) begin
                  state_d                = ST_MUL;
                  cnt_d                  = CW'(MULT_CYCLES);
                  {pend_hi_d, pend_lo_d} = arith_res;
               end else if (op_div) begin
                  state_d                = ST_DIV;
                  cnt_d                  = CW'(DIV_CYCLES);
                  {pend_hi_d, pend_lo_d} = arith_res;
               end else if (mdu_op_E == OP_MTHI) begin
                  hi_d = src_a_E;
               end else if (mdu_op_E == OP_MTLO) begin
                  lo_d = src_a_E;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            // Issue while busy is dropped here; the hazard unit keeps it from happening.
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign stall_req = mdu_use_D & (busy | (mdu_valid_E & (op_mul | op_div)));
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      mdu_rd_E = 32'd0;
      if (mdu_op_E == OP_MFHI)      mdu_rd_E = hi_q;
      else if (mdu_op_E == OP_MFLO) mdu_rd_E = lo_q;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      assert (reset || !(busy && mdu_valid_E))
         else $error("mdu_ctrl: op issued while busy is ignored");
   end
`endif

endmodule
